// File: rtl/res_st_alloc_if.sv
// res_st_alloc_if: dispatch/issue-side handshake bundle for the reservation station slot allocator
interface res_st_alloc_if #(
    parameter int RES_ST_DEPTH = 32,
    parameter int ADDR_W = $clog2(RES_ST_DEPTH)
);
    logic alloc_req;
    logic alloc_gnt;
    logic [ADDR_W-1:0] alloc_addr;
    logic rel1_en;
    logic [ADDR_W-1:0] rel1_addr;
    logic rel2_en;
    logic [ADDR_W-1:0] rel2_addr;
    logic flush;
    logic [RES_ST_DEPTH-1:0] busy_mask;
    logic [ADDR_W:0] free_cnt;
    logic full;
    logic empty;
    logic err;
    modport master (
        output alloc_req, rel1_en, rel1_addr, rel2_en, rel2_addr, flush,
        input alloc_gnt, alloc_addr, busy_mask, free_cnt, full, empty, err
    );
    modport slave (
        input alloc_req, rel1_en, rel1_addr, rel2_en, rel2_addr, flush,
        output alloc_gnt, alloc_addr, busy_mask, free_cnt, full, empty, err
    );
endinterface

// File: rtl/res_st_alloc.sv
// res_st_alloc: reservation station free-list, hands out lowest free entry and reclaims up to two per cycle
module res_st_alloc #(
    parameter int RES_ST_DEPTH = 32,
    parameter int ADDR_W = $clog2(RES_ST_DEPTH)
) (
    input logic clk,
    input logic rst,
    res_st_alloc_if.slave bus
);
    logic [RES_ST_DEPTH-1:0] busy_q, busy_d;
    logic [ADDR_W:0] free_q, free_d;
    logic err_q, err_d;
    logic [ADDR_W-1:0] addr;
    logic full, gnt, v1, v2, same, bad;
    always_comb begin
        addr = '0;
        for (int i = RES_ST_DEPTH - 1; i >= 0; i--)
            if (!busy_q[i]) addr = ADDR_W'(i);
    end
    always_comb begin
        full = free_q == '0;
        gnt = bus.alloc_req & ~full & ~bus.flush & rst;
        same = bus.rel1_addr == bus.rel2_addr;
        v1 = bus.rel1_en & busy_q[bus.rel1_addr];
        v2 = bus.rel2_en & busy_q[bus.rel2_addr] & ~(v1 & same);
        bad = (bus.rel1_en & ~busy_q[bus.rel1_addr]) | (bus.rel2_en & ~busy_q[bus.rel2_addr]) |
              (bus.rel1_en & bus.rel2_en & same);
        busy_d = busy_q;
        if (gnt) busy_d[addr] = 1'b1;
        if (v1) busy_d[bus.rel1_addr] = 1'b0;
        if (v2) busy_d[bus.rel2_addr] = 1'b0;
        free_d = free_q - (ADDR_W + 1)'(gnt) + (ADDR_W + 1)'(v1) + (ADDR_W + 1)'(v2);
        err_d = err_q | (bad & ~bus.flush);
        busy_d = bus.flush ? '0 : busy_d;
        free_d = bus.flush ? (ADDR_W + 1)'(RES_ST_DEPTH) : free_d;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
            free_q <= (ADDR_W + 1)'(RES_ST_DEPTH);
            err_q <= 1'b0;
        end else begin
            busy_q <= busy_d;
            free_q <= free_d;
            err_q <= err_d;
        end
    end
    assign bus.alloc_gnt = gnt;
    assign bus.alloc_addr = addr;
    assign bus.busy_mask = busy_q;
    assign bus.free_cnt = free_q;
    assign bus.full = full;
    assign bus.empty = free_q == (ADDR_W + 1)'(RES_ST_DEPTH);
    assign bus.err = err_q;
endmodule

// File: doc/res_st_alloc.md
# res_st_alloc

Slot allocator and free-list manager for the reservation station storage array. It hands a free entry address to dispatch each time dispatch writes a new micro-op. It reclaims entries as issue logic reads them out through the two read ports. It exports an occupancy mask so issue/wakeup logic knows which entries hold live micro-ops.

## Interface
- RES_ST_DEPTH, 32: number of reservation station entries; power of two, ≥4.
- ADDR_W, $clog2(RES_ST_DEPTH): entry address width; must match res_st_addr_t.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low. Sampled on rising edge of clk; rst=0 resets all state.
- alloc_req  in  1  dispatch requests one entry this cycle.
- alloc_gnt  out  1  entry granted; dispatch may assert its write enable with alloc_addr this cycle.
- alloc_addr  out  ADDR_W  lowest-index free entry; valid whenever full=0.
- rel1_en  in  1  release request 1, paired with read port 1.
- rel1_addr  in  ADDR_W  entry released by request 1.
- rel2_en  in  1  release request 2, paired with read port 2.
- rel2_addr  in  ADDR_W  entry released by request 2.
- flush  in  1  pipeline flush; frees every entry.
- busy_mask  out  RES_ST_DEPTH  bit i=1 means entry i is allocated.
- free_cnt  out  ADDR_W+1  number of free entries, 0..RES_ST_DEPTH.
- full  out  1  free_cnt==0.
- empty  out  1  free_cnt==RES_ST_DEPTH.
- err  out  1  sticky protocol error flag.

## Operation
- State: busy_mask register, free_cnt register, err register.
- Grant: alloc_gnt = alloc_req & ~full & ~flush & rst. The grant path is combinational within the cycle.
- alloc_addr is a priority encode of the lowest zero bit of registered busy_mask. It is 0 when full.
- On alloc_gnt, busy_mask[alloc_addr] is set at the next edge.
- Release k (k=1,2) is valid when relk_en=1 and busy_mask[relk_addr]=1. A valid release clears that bit at the next edge.
- Release of an entry whose busy bit is 0: ignored; err set.
- rel1_en & rel2_en with rel1_addr==rel2_addr on a busy entry: one release applied, free_cnt +1; err set.
- Alloc and release in the same cycle: both applied. The granted address is free and a released address is busy, so they cannot collide.
- free_cnt next = free_cnt − alloc_gnt + number of distinct valid releases. It saturates in neither direction; the invariant free_cnt == popcount(~busy_mask) always holds.
- Flush: busy_mask←0, free_cnt←RES_ST_DEPTH. Flush overrides same-cycle alloc (no grant) and releases. err is not cleared.
- err is cleared only by reset.
- Reset (rst=0 at edge): busy_mask=0, free_cnt=RES_ST_DEPTH, full=0, empty=1, err=0, alloc_addr=0. alloc_gnt=0 while rst=0. Reset overrides flush, alloc and release.

## Timing
- Allocation latency 0: grant and address are in the same cycle as the request. The entry shows busy from the next cycle.
- One allocation per cycle maximum; up to two releases per cycle.
- A released entry is allocatable from the cycle after the release edge. There is no same-cycle bypass, so full with a concurrent release still denies the grant.
- full, empty, free_cnt, busy_mask and alloc_addr are all register-derived. They are stable for the whole cycle and independent of same-cycle inputs.
- Flush takes effect at the edge. The cycle after flush is identical to the post-reset state except for err.
- Reset asserted mid-operation discards all allocations at that edge.

## Test plan
- Reset then fill: hold alloc_req=1 for 32 cycles. Grants return addresses 0,1,…,31 in order. free_cnt decrements to 0. full=1 from cycle 32, and alloc_gnt=0 on cycle 33 with alloc_req=1.
- Full plus release: with all entries busy, release addr 5 while alloc_req=1. There is no grant that cycle. Next cycle alloc_gnt=1, alloc_addr=5, and free_cnt goes 1→0.
- Dual release plus alloc: with entries 0..9 busy, assert rel1=3, rel2=7 and alloc_req in the same cycle. Address 10 is granted. Next cycle busy_mask has bits 3 and 7 clear and bit 10 set, free_cnt=23, and alloc_addr=3.
- Error cases: release free entry 20 → err=1 and free_cnt unchanged. Same-address dual release of busy entry 2 → free_cnt +1 only and err=1. err stays 1 through a later flush.
- Flush with a concurrent alloc request: 12 entries busy, flush=1 and alloc_req=1. alloc_gnt=0. Next cycle busy_mask=0, free_cnt=32, empty=1.
- Reset mid-operation: 8 entries busy, drive rst=0 for one edge while releases and alloc are asserted. Afterwards all outputs hold reset values, including err=0.
